// File: rtl/fb_mem_arbiter.sv
// Round-robin arbiter sharing one framebuffer memory port among NUM_REQ requesters; read data is routed back by tag.
// Optional macro ARB_BURST_LOCK_EN: the current owner keeps priority for up to MAX_BURST consecutive beats.
module fb_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int MEM_RD_LAT = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NUM_REQ*32-1:0]  req_data,
    input  logic [NUM_REQ*16-1:0]  req_addr,
    input  logic [NUM_REQ*4-1:0]   req_wben,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ-1:0]     req_rts,
    output logic [NUM_REQ-1:0]     req_rtr,
    output logic [31:0]            rd_data,
    output logic [NUM_REQ-1:0]     rd_valid,
    output logic [15:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wben,
    output logic                   mem_we,
    output logic                   mem_en,
    input  logic [31:0]            mem_rdata
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_win_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any;
    logic               w_xfer;
    logic [31:0]        w_data;
    logic [15:0]        w_addr;
    logic [3:0]         w_wben;
    logic               w_op;
    int                 w_idx;

    // Search from r_ptr upward, wrapping; the first requester with rts wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_gnt  = '0;
        w_data = '0;
        w_addr = '0;
        w_wben = '0;
        w_op   = 1'b0;
        w_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && req_rts[w_idx]) begin
                w_any        = 1'b1;
                w_win        = PTR_W'(w_idx);
                w_gnt[w_idx] = 1'b1;
                w_data       = req_data[32*w_idx +: 32];
                w_addr       = req_addr[16*w_idx +: 16];
                w_wben       = req_wben[4*w_idx +: 4];
                w_op         = req_op[w_idx];
            end
        end
    end

    assign req_rtr   = rst_ ? w_gnt : '0;
    assign w_xfer    = rst_ & w_any;
    assign w_win_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

`ifdef ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PTR_W-1:0] r_owner;
    logic [PTR_W-1:0] w_owner_nxt;
    logic             r_locked;

    assign w_cnt_nxt   = (r_locked && (w_win == r_owner)) ? r_cnt + 1'b1 : CNT_W'(1);
    assign w_owner_nxt = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Pointer parks on the owner while it streams; it advances when the burst fills or the owner lets go.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_owner  <= '0;
            r_locked <= 1'b0;
        end else if (w_xfer) begin
            r_owner <= w_win;
            if (int'(w_cnt_nxt) >= MAX_BURST) begin
                r_ptr    <= w_win_nxt;
                r_cnt    <= '0;
                r_locked <= 1'b0;
            end else begin
                r_ptr    <= w_win;
                r_cnt    <= w_cnt_nxt;
                r_locked <= 1'b1;
            end
        end else if (r_locked && !req_rts[r_owner]) begin
            r_ptr    <= w_owner_nxt;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_win_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wben  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en   <= w_xfer;
            mem_we   <= w_xfer & w_op;
            mem_wben <= (w_xfer && w_op) ? w_wben : 4'h0;
            if (w_xfer) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_data;
            end
        end
    end

    // Tag stage k holds the read issued k+1 cycles ago; the last stage lines up with mem_rdata.
    logic [MEM_RD_LAT:0] r_tag_vld;
    logic [PTR_W-1:0]    r_tag_id [MEM_RD_LAT:0];

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_tag_vld <= '0;
            for (int k = 0; k <= MEM_RD_LAT; k++) r_tag_id[k] <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[MEM_RD_LAT-1:0], w_xfer & ~w_op};
            r_tag_id[0] <= w_win;
            for (int k = 1; k <= MEM_RD_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
            rd_valid <= r_tag_vld[MEM_RD_LAT] ? (NUM_REQ'(1) << r_tag_id[MEM_RD_LAT]) : '0;
            if (r_tag_vld[MEM_RD_LAT]) rd_data <= mem_rdata;
        end
    end
endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares the single framebuffer memory port among NUM_REQ drawing and refresh requesters, for example fill_rect_engine, other raster engines and the display fetch.
- Each requester presents the standard engine-to-arbiter interface: data, addr, wben, op, with an rts/rtr handshake.
- Round-robin grant, at most one memory access accepted per cycle, registered memory-side outputs.
- Read data is routed back to the requester that issued the read.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MEM_RD_LAT, 1, memory read latency in cycles from registered mem_en to valid mem_rdata (1..4).
- MAX_BURST, 16, maximum consecutive beats for one requester; used only with ARB_BURST_LOCK_EN.

Ports:
- clk  in  1  system clock
- rst_  in  1  synchronous active-low reset
- req_data  in  NUM_REQ*32  write data; requester i at [32*i+31:32*i]
- req_addr  in  NUM_REQ*16  word address; requester i at [16*i+15:16*i]
- req_wben  in  NUM_REQ*4  byte write enables; requester i at [4*i+3:4*i]
- req_op  in  NUM_REQ  1 = write, 0 = read
- req_rts  in  NUM_REQ  requester i has a valid access
- req_rtr  out  NUM_REQ  arbiter accepts requester i this cycle
- rd_data  out  32  read return data, shared by all requesters
- rd_valid  out  NUM_REQ  one-hot; rd_data belongs to requester i
- mem_addr  out  16  registered memory address
- mem_wdata  out  32  registered write data
- mem_wben  out  4  registered byte enables; forced 0 on reads
- mem_we  out  1  registered write strobe
- mem_en  out  1  registered access strobe
- mem_rdata  in  32  memory read data, valid MEM_RD_LAT cycles after mem_en with mem_we=0

Behaviour:
- Reset (rst_=0 at a clk edge):
  - req_rtr is 0 while rst_=0.
  - mem_en, mem_we, mem_wben, mem_addr, mem_wdata, rd_valid and rd_data are all 0.
  - Round-robin pointer resets to 0.
  - Read-tag pipeline is cleared, so in-flight reads never produce rd_valid.
  - The burst counter is cleared.
- Arbitration is combinational within the cycle:
  - Winner = first i with req_rts[i]=1, searching i = ptr, ptr+1, … modulo NUM_REQ.
  - req_rtr is one-hot on the winner, all 0 if no rts.
  - req_rtr never depends on anything that depends on req_rtr.
- Transfer occurs when req_rts[i] & req_rtr[i] are both high at the rising edge.
  - Requesters hold data/addr/wben/op stable while rts=1 and rtr=0.
  - Requesters may deassert rts at any time without a transfer.
- Pointer update: after a transfer by requester w, ptr <= (w+1) mod NUM_REQ. With no transfer, ptr holds.
- Memory issue: on a transfer, the next cycle drives:
  - mem_en=1;
  - mem_we=op;
  - mem_addr, mem_wdata taken from the requester;
  - mem_wben = op ? wben : 0.
  - With no transfer: mem_en=0, mem_we=0, mem_wben=0; addr/wdata hold their last value.
- Throughput: one access per cycle, back-to-back, no idle cycles required.
- Write with wben=0: still issued with mem_we=1 and mem_wben=0 (memory ignores it); counts as a grant.
- Read return:
  - A read accepted at edge T produces rd_valid[i]=1 and rd_data=mem_rdata for exactly one cycle, after edge T+1+MEM_RD_LAT.
  - A tag shift register of depth MEM_RD_LAT+1 carries {valid, requester id}.
  - rd_data is registered and holds its value when rd_valid=0.
- Reads and writes are strictly in order at the memory.
  - A write accepted after a read to the same address does not affect that read's data, provided the memory is read-before-write.
- Simultaneous rts from all requesters: each is granted once every NUM_REQ cycles. No starvation; worst-case wait is NUM_REQ-1 cycles.
- Reset mid-operation: the same cycle's edge clears everything; outstanding handshakes are lost and requesters re-present their requests.

Optional Feature:
- ARB_BURST_LOCK_EN, defined:
  - After a grant to w, w keeps priority (ptr is not advanced) while req_rts[w] stays 1.
  - The lock lasts up to MAX_BURST consecutive transfers.
  - The burst counter reloads whenever the owner changes.
  - On reaching MAX_BURST transfers, or on the owner dropping rts, ptr <= (w+1) mod NUM_REQ.
  - Purpose: lets fill_rect stream a row without interleaving.
- ARB_BURST_LOCK_EN, undefined: pure per-beat round-robin as above; no burst counter logic.

Test Plan:
- Reset, then single write from req0 (addr 16'h0020, data 32'h03020101, wben 4'hF, op=1): rtr[0]=1 the same cycle; the next cycle shows mem_en=1, mem_we=1, mem_addr=16'h0020, mem_wbens=4'hF.
- Single read from req1 (addr 16'h0004), memory model returning 32'hCAFE0004 with MEM_RD_LAT=1: rd_valid=3'b010 and rd_data=32'hCAFE0004 exactly 2 cycles after the handshake.
- All three rts held high for 9 cycles, lock macro off: grant order 0,1,2,0,1,2,0,1,2; mem_addr sequence matches that order.
- Lock macro on, MAX_BURST=4, req0 and req2 constantly requesting: grants 0,0,0,0,2,2,2,2,0,…
- rst_ pulled low for one cycle while two reads are in flight: no rd_valid afterwards, ptr=0, mem_en=0 on the next cycle.
- req2 rts held with rtr=0 while req0 is granted: req2 data stays unchanged; req2 is granted on the following cycle.
